mul4_fitness_scorer: RTL and testbench
======================================

// Module: mul4_fitness_scorer
// PURPOSE
// - Downstream scoring stage for the bit-sliced 2x2-bit vector multiplier individuals.
// - Each lane i (0..LANES-1) forms A={a1[i],a0[i]} and B={b1[i],b0[i]}.
//   The golden product is P=A*B (4 bits); the candidate drives {y3[i],y2[i],y1[i],y0[i]}.
// - Accepts NUM_VEC input/output vector sets via valid/ready.
//   Accumulates the count of output bits that match the golden product.
// - Reports the final fitness score to the tournament controller.
// PARAMETERS
// - LANES    16  bit-slices per vector word
// - NUM_VEC  16  vector sets scored per evaluation run
// - ACC_W    16  score accumulator width; must hold 4*LANES*NUM_VEC (default max 1024)
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       asynchronous active-low reset
// - start      in   1       begin evaluation run (sampled in IDLE/DONE only)
// - in_valid   in   1       a*/b*/y* carry a vector set
// - in_ready   out  1       scorer accepts a set this cycle
// - a1,a0,b1,b0  in  LANES  multiplier operand bit-planes
// - y3,y2,y1,y0  in  LANES  candidate product bit-planes
// - busy       out  1       run in progress (RUN or DRAIN)
// - done       out  1       score valid; held until next start
// - score      out  ACC_W   correct-bit total for the run
// - perfect    out  1       score == 4*LANES*NUM_VEC (valid while done)
// - vec_count  out  $clog2(NUM_VEC+1)  vector sets accepted this run
// BEHAVIOUR
// - Reset (async, rst_n=0): FSM=IDLE; in_ready=0, busy=0, done=0, score=0, perfect=0, vec_count=0.
//   Reset also clears the pipeline valid flags.
// - FSM states and transitions:
//   IDLE -> RUN on start.
//   RUN -> DRAIN on the edge accepting vector NUM_VEC.
//   DRAIN -> DONE once the pipeline is empty.
//   DONE -> RUN on start.
// - Entering RUN (from IDLE or DONE): score, vec_count and done clear on the same edge.
// - Handshake:
//   - in_ready=1 only in RUN.
//   - A transfer happens on an edge with in_valid&&in_ready.
//   - in_valid low cycles are gaps: no transfer, no score change.
// - start is ignored while busy; it has no effect in RUN or DRAIN.
// - Pipeline stage 1 (registered on the transfer edge):
//   - Golden per lane: g0=a0&b0; g1=(a1&b0)^(a0&b1); g2=(a1&b1)&~(a0&b0); g3=a1&a0&b1&b0.
//   - Match planes: m_k = ~(y_k ^ g_k).
// - Pipeline stage 2 (next edge): score += popcount({m3,m2,m1,m0}), range 0..4*LANES.
// - Latency: a transfer at edge k updates score at edge k+1.
// - done timing: done rises at edge k+2 after the last transfer (k).
//   score and perfect are stable whenever done=1.
// - Arithmetic: unsigned; no saturation needed since ACC_W covers the max.
// - Elaboration check: fail if ACC_W is too narrow for 4*LANES*NUM_VEC.
// - vec_count increments per transfer and reaches NUM_VEC exactly; no wrap.
// - Reset mid-run: everything returns to reset values immediately; any partial score is discarded.
// TESTING
// - All cases use inputs a1=FF00, a0=F0F0, b1=CCCC, b0=AAAA (all 16 A,B combos).
//   Golden outputs: y0=A0A0, y1=6AC0, y2=4C00, y3=8000.
// - Perfect run: start, then 16 transfers with the golden y.
//   -> done 2 edges after the last transfer; score=1024, perfect=1, vec_count=16.
// - All-zero candidate: y*=0000 for 16 transfers.
//   -> 50 correct bits/vector; score=800, perfect=0.
// - Valid gaps: same as the perfect run, but in_valid low on every other cycle.
//   -> score=1024; in_ready stays high through the gaps; vec_count=16.
// - Busy guard: pulse start during RUN and during DRAIN -> no restart, score unaffected.
//   Then start in DONE -> done=0 and score=0 on that edge.
// - Reset mid-run: drop rst_n after 5 transfers.
//   -> all outputs go to reset values asynchronously; a new start with 16 golden vectors gives score=1024.
// - Single-bit error: y0=A0A1 in exactly one vector -> score=1023, perfect=0.

Source files
------------

// File: rtl/mul4_fitness_scorer_if.sv
// Vector-set handshake bundle between the stimulus source and the fitness scorer:
// operand bit-planes, candidate product bit-planes and the valid/ready pair.
interface mul4_fitness_scorer_if #(
    parameter int LANES = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] a1;
    logic [LANES-1:0] a0;
    logic [LANES-1:0] b1;
    logic [LANES-1:0] b0;
    logic [LANES-1:0] y3;
    logic [LANES-1:0] y2;
    logic [LANES-1:0] y1;
    logic [LANES-1:0] y0;

    modport master (
        output in_valid,
        output a1, a0, b1, b0,
        output y3, y2, y1, y0,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  a1, a0, b1, b0,
        input  y3, y2, y1, y0,
        output in_ready
    );
endinterface

// File: rtl/mul4_fitness_scorer.sv
// Scores a bit-sliced 2x2-bit multiplier candidate: counts product bits that
// match the golden A*B over NUM_VEC accepted vector sets.
module mul4_fitness_scorer #(
    parameter int LANES   = 16,
    parameter int NUM_VEC = 16,
    parameter int ACC_W   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    mul4_fitness_scorer_if.slave             bus,
    output logic                             busy,
    output logic                             done,
    output logic [ACC_W-1:0]                 score,
    output logic                             perfect,
    output logic [$clog2(NUM_VEC+1)-1:0]     vec_count
);
    localparam int VC_W      = $clog2(NUM_VEC + 1);
    localparam int PC_W      = $clog2(4 * LANES + 1);
    localparam int MAX_SCORE = 4 * LANES * NUM_VEC;
    localparam logic [ACC_W-1:0] MAX_SCORE_W = ACC_W'(MAX_SCORE);

    generate
        if (ACC_W < $clog2(MAX_SCORE + 1)) begin : g_acc_w_check
            $error("mul4_fitness_scorer: ACC_W too narrow for 4*LANES*NUM_VEC");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [4*LANES-1:0] v);
        logic [PC_W-1:0] cnt;
        cnt = {PC_W{1'b0}};
        for (int i = 0; i < 4 * LANES; i++) begin
            cnt = cnt + PC_W'(v[i]);
        end
        return cnt;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic              in_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              perfect_r;
    logic [ACC_W-1:0]  score_r;
    logic [VC_W-1:0]   vec_count_r;
    logic              s1_valid_r;
    logic [LANES-1:0]  m0_r, m1_r, m2_r, m3_r;

    logic              xfer_s;
    logic              last_s;
    logic              enter_run_s;
    logic [LANES-1:0]  g0_s, g1_s, g2_s, g3_s;
    logic [PC_W-1:0]   match_cnt_s;

    assign xfer_s      = bus.in_valid && in_ready_r;
    assign last_s      = xfer_s && (vec_count_r == VC_W'(NUM_VEC - 1));
    assign enter_run_s = (state_s == RUN) && (state_r != RUN);

    // Golden 2x2 product per lane, written out as sum-of-products bit planes
    assign g0_s = bus.a0 & bus.b0;
    assign g1_s = (bus.a1 & bus.b0) ^ (bus.a0 & bus.b1);
    assign g2_s = (bus.a1 & bus.b1) & ~(bus.a0 & bus.b0);
    assign g3_s = bus.a1 & bus.a0 & bus.b1 & bus.b0;

    assign match_cnt_s = popcount({m3_r, m2_r, m1_r, m0_r});

    // Next-state logic; start only matters when no run is in flight
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DRAIN;
                else        state_s = RUN;
            end
            DRAIN: begin
                if (!s1_valid_r) state_s = DONE;
                else             state_s = DRAIN;
            end
            DONE: begin
                if (start) state_s = RUN;
                else       state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered status outputs, all derived from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            perfect_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == RUN);
            busy_r     <= (state_s == RUN) || (state_s == DRAIN);
            done_r     <= (state_s == DONE);
            // score is already final when DRAIN hands over to DONE
            perfect_r  <= (state_s == DONE) && (score_r == MAX_SCORE_W);
        end
    end

    // Stage 1: capture per-bit match planes on each accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            m0_r       <= {LANES{1'b0}};
            m1_r       <= {LANES{1'b0}};
            m2_r       <= {LANES{1'b0}};
            m3_r       <= {LANES{1'b0}};
        end else begin
            s1_valid_r <= xfer_s;
            if (xfer_s) begin
                m0_r <= ~(bus.y0 ^ g0_s);
                m1_r <= ~(bus.y1 ^ g1_s);
                m2_r <= ~(bus.y2 ^ g2_s);
                m3_r <= ~(bus.y3 ^ g3_s);
            end else begin
                m0_r <= m0_r;
                m1_r <= m1_r;
                m2_r <= m2_r;
                m3_r <= m3_r;
            end
        end
    end

    // Stage 2 accumulator and transfer counter; a new run clears both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_r     <= {ACC_W{1'b0}};
            vec_count_r <= {VC_W{1'b0}};
        end else begin
            if (enter_run_s) begin
                score_r <= {ACC_W{1'b0}};
            end else if (s1_valid_r) begin
                score_r <= score_r + ACC_W'(match_cnt_s);
            end else begin
                score_r <= score_r;
            end
            if (enter_run_s) begin
                vec_count_r <= {VC_W{1'b0}};
            end else if (xfer_s) begin
                vec_count_r <= vec_count_r + VC_W'(1);
            end else begin
                vec_count_r <= vec_count_r;
            end
        end
    end

    assign bus.in_ready = in_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign score        = score_r;
    assign perfect      = perfect_r;
    assign vec_count    = vec_count_r;
endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Directed bench for mul4_fitness_scorer: perfect, all-zero, gapped, busy-guard,
// mid-run reset and single-bit-error runs with hand-computed scores.
module tb_mul4_fitness_scorer;
    localparam int LANES   = 16;
    localparam int NUM_VEC = 16;
    localparam int ACC_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy, done, perfect;
    logic [ACC_W-1:0] score;
    logic [4:0]       vec_count;
    int               checks = 0;
    int               errors = 0;

    mul4_fitness_scorer_if #(.LANES(LANES)) bus();

    mul4_fitness_scorer #(.LANES(LANES), .NUM_VEC(NUM_VEC), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .score     (score),
        .perfect   (perfect),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [15:0] y3, input logic [15:0] y2,
                        input logic [15:0] y1, input logic [15:0] y0, input bit gap);
        if (gap) begin
            bus.in_valid = 1'b0;
            step();
            chk("gap_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end
        bus.y3 = y3; bus.y2 = y2; bus.y1 = y1; bus.y0 = y0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Full run: optional start, NUM_VEC transfers, then drain and final checks
    task automatic run(input string tag, input bit do_start, input bit zero, input bit gap,
                       input int err_vec, input int exp_first, input int exp_score,
                       input bit exp_perfect);
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk({tag, "_start_score"}, {16'd0, score}, 32'd0);
            chk({tag, "_start_ready"}, {31'd0, bus.in_ready}, 32'd1);
        end
        for (int i = 0; i < NUM_VEC; i++) begin
            if (zero)
                xfer(16'h0000, 16'h0000, 16'h0000, 16'h0000, gap);
            else if (i == err_vec)
                xfer(16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A1, gap);
            else
                xfer(16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0, gap);
            if (i == 0 && !gap) chk({tag, "_latency0"}, {16'd0, score}, 32'd0);
            if (i == 1 && !gap) chk({tag, "_latency1"}, {16'd0, score}, exp_first);
        end
        chk({tag, "_vec_count"}, {27'd0, vec_count}, 32'd16);
        chk({tag, "_drain_ready"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_drain_busy"}, {31'd0, busy}, 32'd1);
        step();
        chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
        step();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_score"}, {16'd0, score}, exp_score);
        chk({tag, "_perfect"}, {31'd0, perfect}, {31'd0, exp_perfect});
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a1 = 16'hFF00; bus.a0 = 16'hF0F0; bus.b1 = 16'hCCCC; bus.b0 = 16'hAAAA;
        bus.y3 = 16'h0000; bus.y2 = 16'h0000; bus.y1 = 16'h0000; bus.y0 = 16'h0000;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_score", {16'd0, score}, 32'd0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_ready", {31'd0, bus.in_ready}, 32'd0);

        run("perfect", 1'b1, 1'b0, 1'b0, -1, 64, 1024, 1'b1);
        run("zero", 1'b1, 1'b1, 1'b0, -1, 50, 800, 1'b0);
        run("gaps", 1'b1, 1'b0, 1'b1, -1, 64, 1024, 1'b1);

        // Busy guard: start pulses during RUN and DRAIN must be ignored
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) xfer(16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("guard_run_count", {27'd0, vec_count}, 32'd8);
        chk("guard_run_score", {16'd0, score}, 32'd512);
        for (int i = 0; i < 8; i++) xfer(16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("guard_drain_busy", {31'd0, busy}, 32'd1);
        chk("guard_drain_count", {27'd0, vec_count}, 32'd16);
        step();
        chk("guard_done", {31'd0, done}, 32'd1);
        chk("guard_score", {16'd0, score}, 32'd1024);
        step();
        chk("guard_done_hold", {31'd0, done}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_score", {16'd0, score}, 32'd0);
        chk("restart_count", {27'd0, vec_count}, 32'd0);
        chk("restart_perfect", {31'd0, perfect}, 32'd0);

        // Continue this run with a single flipped bit in vector 5
        run("one_err", 1'b0, 1'b0, 1'b0, 5, 64, 1023, 1'b0);

        // Reset mid-run
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) xfer(16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0, 1'b0);
        chk("pre_reset_count", {27'd0, vec_count}, 32'd5);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("mid_rst_score", {16'd0, score}, 32'd0);
        chk("mid_rst_count", {27'd0, vec_count}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run("post_reset", 1'b1, 1'b0, 1'b0, -1, 64, 1024, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
